// File: rtl/sawtooth_capture.sv
// Sawtooth receiver: detects waveform wraps, measures period and min/max amplitude
// per period, and captures one wrap-aligned buffer of samples for readback.
module sawtooth_capture #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 10,
  parameter int PERIOD_W = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic                sample_valid,
  input  logic                arm,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                busy,
  output logic                done,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [DATA_W-1:0]   peak_max,
  output logic [DATA_W-1:0]   peak_min
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

  state_t              state_q, state_d;
  logic                prev_valid_q, prev_valid_d;
  logic [DATA_W-1:0]   prev_sample_q, prev_sample_d;
  logic                seen_wrap_q, seen_wrap_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic [DATA_W-1:0]   run_min_q, run_min_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic [DATA_W-1:0]   peak_max_q, peak_max_d;
  logic [DATA_W-1:0]   peak_min_q, peak_min_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   rd_data_q;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic                wrap;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign wrap = sample_valid && prev_valid_q && (sample_in < prev_sample_q);

  // Measurement path; runs regardless of the capture FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    prev_valid_d   = prev_valid_q;
    prev_sample_d  = prev_sample_q;
    seen_wrap_d    = seen_wrap_q;
    cnt_d          = cnt_q;
    run_max_d      = run_max_q;
    run_min_d      = run_min_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    peak_max_d     = peak_max_q;
    peak_min_d     = peak_min_q;
    if (sample_valid) begin
      prev_valid_d  = 1'b1;
      prev_sample_d = sample_in;
      if (wrap) begin
        cnt_d       = PERIOD_W'(1);
        run_max_d   = sample_in;
        run_min_d   = sample_in;
        seen_wrap_d = 1'b1;
        if (seen_wrap_q) begin
          period_d       = cnt_q;
          peak_max_d     = run_max_q;
          peak_min_d     = run_min_q;
          period_valid_d = 1'b1;
        end
      end else begin
        cnt_d     = (cnt_q == '1) ? cnt_q : cnt_q + PERIOD_W'(1);
        run_max_d = (sample_in > run_max_q) ? sample_in : run_max_q;
        run_min_d = (sample_in < run_min_q) ? sample_in : run_min_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm) state_d = ARMED;
      ARMED:   if (wrap) state_d = CAPTURE;
      CAPTURE: if (sample_valid && waddr_q == '1) state_d = DONE;
      DONE:    if (arm) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q == ARMED) || (state_q == CAPTURE);
    done    = (state_q == DONE);
    wr_en   = 1'b0;
    wr_addr = waddr_q;
    waddr_d = waddr_q;
    unique case (state_q)
      ARMED: if (wrap) begin
        wr_en   = 1'b1;
        wr_addr = '0;
        waddr_d = ADDR_W'(1);
      end
      CAPTURE: if (sample_valid) begin
        wr_en   = 1'b1;
        waddr_d = waddr_q + ADDR_W'(1);
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q        <= IDLE;
      prev_valid_q   <= 1'b0;
      prev_sample_q  <= '0;
      seen_wrap_q    <= 1'b0;
      cnt_q          <= '0;
      run_max_q      <= '0;
      run_min_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      peak_max_q     <= '0;
      peak_min_q     <= '0;
      waddr_q        <= '0;
    end else begin
      state_q        <= state_d;
      prev_valid_q   <= prev_valid_d;
      prev_sample_q  <= prev_sample_d;
      seen_wrap_q    <= seen_wrap_d;
      cnt_q          <= cnt_d;
      run_max_q      <= run_max_d;
      run_min_q      <= run_min_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      peak_max_q     <= peak_max_d;
      peak_min_q     <= peak_min_d;
      waddr_q        <= waddr_d;
    end
  end

  // NOTE: the buffer RAM has no reset so it maps onto block RAM; contents survive sys_rst.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[wr_addr] <= sample_in;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) rd_data_q <= '0;
    else         rd_data_q <= mem[rd_addr];
  end

  assign rd_data      = rd_data_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign peak_max     = peak_max_q;
  assign peak_min     = peak_min_q;

endmodule

// File: tb/tb_sawtooth_capture.sv
// Randomized bench for sawtooth_capture: a queue-based model of periods and capture
// is compared against the DUT on every falling edge, plus literal scenario checks.
module tb_sawtooth_capture;

  localparam int DW    = 4;
  localparam int AW    = 10;
  localparam int PW    = 12;  // narrow period counter keeps the saturation run short
  localparam int DEPTH = 1 << AW;
  localparam int SAT   = (1 << PW) - 1;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic [DW-1:0] sample_in = '0;
  logic          sample_valid = 1'b0;
  logic          arm = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          busy, done, period_valid;
  logic [PW-1:0] period;
  logic [DW-1:0] peak_max, peak_min;

  sawtooth_capture #(.DATA_W(DW), .ADDR_W(AW), .PERIOD_W(PW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .sample_in(sample_in),
    .sample_valid(sample_valid), .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .period(period), .period_valid(period_valid),
    .peak_max(peak_max), .peak_min(peak_min)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_prev_ok;
  int m_prev;
  int m_wraps;
  int m_seg[$];          // valid samples of the period in progress, wrap sample first
  int e_period, e_max, e_min;
  bit e_pv;
  bit m_armed, m_capturing, m_done;
  int m_widx;
  int m_mem[DEPTH];
  bit m_written[DEPTH];
  int e_rd;
  bit e_rd_known;

  task automatic model_reset();
    m_prev_ok = 0; m_prev = 0; m_wraps = 0; m_seg.delete();
    e_period = 0; e_max = 0; e_min = 0; e_pv = 0;
    m_armed = 0; m_capturing = 0; m_done = 0; m_widx = 0;
    e_rd = 0; e_rd_known = 1;
  endtask

  task automatic model_step();
    bit v, a, is_wrap;
    int s, ra, mx, mn;
    v = sample_valid; s = int'(sample_in); a = arm; ra = int'(rd_addr);
    e_rd_known = m_written[ra];
    e_rd = m_mem[ra];
    is_wrap = v && m_prev_ok && (s < m_prev);
    if (m_capturing && v) begin
      m_mem[m_widx] = s; m_written[m_widx] = 1; m_widx++;
      if (m_widx == DEPTH) begin m_capturing = 0; m_done = 1; end
    end else if (m_armed && is_wrap) begin
      m_mem[0] = s; m_written[0] = 1; m_widx = 1;
      m_armed = 0; m_capturing = 1;
    end else if (!m_armed && !m_capturing && a) begin
      m_armed = 1; m_done = 0;
    end
    if (v) begin
      if (is_wrap) begin
        m_wraps++;
        if (m_wraps >= 2) begin
          mx = m_seg[0]; mn = m_seg[0];
          foreach (m_seg[i]) begin
            if (m_seg[i] > mx) mx = m_seg[i];
            if (m_seg[i] < mn) mn = m_seg[i];
          end
          e_period = (m_seg.size() > SAT) ? SAT : m_seg.size();
          e_max = mx; e_min = mn; e_pv = 1;
        end
        m_seg.delete();
      end
      m_seg.push_back(s);
      m_prev_ok = 1; m_prev = s;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or posedge sys_rst);
      if (sys_rst) model_reset();
      else         model_step();
    end
  end

  initial begin
    forever begin
      @(negedge sys_clk);
      check("busy",         busy,         32'(m_armed || m_capturing));
      check("done",         done,         32'(m_done));
      check("period",       period,       e_period);
      check("period_valid", period_valid, 32'(e_pv));
      check("peak_max",     peak_max,     e_max);
      check("peak_min",     peak_min,     e_min);
      if (e_rd_known) check("rd_data", rd_data, e_rd);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  logic [9:0] ph = '0;
  bit short_ramp = 0;
  bit rd_rand = 1;
  bit gap = 0;

  task automatic drive(input bit v, input logic [DW-1:0] s, input bit a);
    sample_valid = v; sample_in = s; arm = a;
    if (rd_rand) rd_addr = AW'($urandom);
    @(posedge sys_clk); #1;
    arm = 1'b0;
  endtask

  task automatic ramp_step(input bit half_rate, input bit a);
    if (half_rate && gap) drive(1'b0, DW'($urandom), a);
    else begin
      drive(1'b1, short_ramp ? ph[8:5] : ph[9:6], a);
      ph++;
    end
    gap = half_rate ? ~gap : 1'b0;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; sample_valid = 1'b0; arm = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    ph = '0; gap = 0;
  endtask

  task automatic run_until_done(input int budget, input bit half_rate);
    int n = 0;
    while (!done && n < budget) begin ramp_step(half_rate, 1'b0); n++; end
    check("done_reached", done, 1);
  endtask

  task automatic read_check(input int k, input int exp);
    rd_rand = 0; rd_addr = AW'(k);
    ramp_step(1'b0, 1'b0);
    check($sformatf("readback[%0d]", k), rd_data, exp);
    rd_rand = 1;
  endtask

  initial begin
    int k, n, p_hold;

    // Reset values while sys_rst is held
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_period", period, 0);
    check("rst_pv", period_valid, 0);
    check("rst_max", peak_max, 0);
    check("rst_min", peak_min, 0);
    check("rst_rd", rd_data, 0);
    #1 sys_rst = 1'b0;

    // 3,9,9,2 twice: equal samples never wrap; first wrap only opens measurement
    drive(1, 3, 0); drive(1, 9, 0); drive(1, 9, 0); drive(1, 2, 0);
    check("seq_first_wrap_pv", period_valid, 0);
    drive(1, 3, 0); drive(1, 9, 0); drive(1, 9, 0); drive(1, 2, 0);
    check("seq_period", period, 4);
    check("seq_max", peak_max, 9);
    // the wrap sample 2 opens the period it is counted in
    check("seq_min", peak_min, 2);
    check("seq_pv", period_valid, 1);

    // Full-rate 1024-sample ramp
    do_reset();
    repeat (3 * 1024 + 10) ramp_step(0, 0);
    check("ramp_period", period, 1024);
    check("ramp_max", peak_max, 15);
    check("ramp_min", peak_min, 0);
    check("ramp_pv", period_valid, 1);

    // Capture aligned to the next wrap
    ramp_step(0, 1);
    check("arm_busy", busy, 1);
    run_until_done(2200, 0);
    check("cap_busy_clear", busy, 0);
    read_check(0, 0);
    read_check(1023, 15);
    repeat (8) begin k = $urandom_range(0, DEPTH - 1); read_check(k, k >> 6); end

    // Half-rate stream, re-armed from DONE
    ramp_step(1, 1);
    run_until_done(4400, 1);
    check("half_period", period, 1024);
    read_check(0, 0);
    read_check(1023, 15);
    repeat (8) begin k = $urandom_range(0, DEPTH - 1); read_check(k, k >> 6); end

    // Constant level after one wrap: ARMED holds, counter saturates
    drive(1, 15, 0); drive(1, 0, 0);
    p_hold = e_period;
    drive(1, 7, 1);
    repeat (SAT + 100) drive(1, 7, 0);
    check("const_busy", busy, 1);
    check("const_done", done, 0);
    check("const_period_hold", period, p_hold);
    drive(1, 0, 0);
    check("sat_period", period, SAT);
    check("sat_max", peak_max, 7);
    check("sat_min", peak_min, 0);

    // Reset in mid-capture, then a fresh capture of a 512-sample ramp
    do_reset();
    short_ramp = 1;
    ramp_step(0, 1);
    n = 0;
    while (!(m_capturing && m_widx == 500) && n < 3000) begin ramp_step(0, 0); n++; end
    check("reached_addr_500", m_widx, 500);
    sys_rst = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_pv", period_valid, 0);
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    ph = '0;
    ramp_step(0, 1);
    run_until_done(3000, 0);
    read_check(0, 0);
    read_check(31, 0);
    read_check(32, 1);
    read_check(511, 15);
    read_check(512, 0);
    read_check(1023, 15);
    repeat (6) begin k = $urandom_range(0, DEPTH - 1); read_check(k, (k % 512) >> 5); end

    // Random traffic, checked by the model alone
    repeat (3000) drive(($urandom_range(0, 3) != 0), DW'($urandom), ($urandom_range(0, 63) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
